// File: rtl/mips_pkg.sv
// mips_pkg: FSM state, stage indices and stall patterns for the pipeline controller
package mips_pkg;
    typedef enum logic [1:0] {RUN, DIV, FLUSH} pipe_state_t;
    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;
    localparam int STG_WB    = 5;
    localparam int NUM_STG   = STG_WB + 1;
    localparam int CNT_W     = 6;
    typedef logic [NUM_STG-1:0] stall_t;
    localparam stall_t STALL_NONE = '0;
    localparam stall_t STALL_ID   = stall_t'((1 << (STG_IDEX + 1)) - 1);
    localparam stall_t STALL_EX   = stall_t'((1 << (STG_EXMEM + 1)) - 1);
    localparam stall_t STALL_MEM  = stall_t'((1 << (STG_MEMWB + 1)) - 1);
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall, flush and divide signals between the pipeline stages and pipe_ctrl
interface pipe_ctrl_if;
    import mips_pkg::*;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        div_start;
    logic        excp_valid;
    logic [31:0] excp_vector;
    stall_t      stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        div_busy;
    logic        div_done;
    logic        div_abort;
    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem, div_start, excp_valid, excp_vector,
        input  stall, flush, new_pc, div_busy, div_done, div_abort
    );
    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem, div_start, excp_valid, excp_vector,
        output stall, flush, new_pc, div_busy, div_done, div_abort
    );
endinterface

// File: rtl/pipe_cnt.sv
// pipe_cnt: loadable down-counter that parks at zero, with zero flag
module pipe_cnt
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] din,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);
    assign zero = cnt == '0;
    // load wins over decrement; counting stops at zero instead of wrapping
    always_ff @(posedge clk)
        if (rst) cnt <= '0;
        else if (load) cnt <= din;
        else if (en && !zero) cnt <= cnt - CNT_W'(1);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall vector, divider occupancy and exception flush sequencing
module pipe_ctrl
    import mips_pkg::*;
#(
    parameter int DIV_CYCLES   = 32,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_,
    pipe_ctrl_if.slave  bus
);
    pipe_state_t      state, state_nxt;
    logic [CNT_W-1:0] div_cnt, fl_cnt;
    logic             div_zero, fl_zero, go_div, go_flush, abort, ex_req;

    pipe_cnt u_div_cnt (
        .clk  (clk),
        .rst  (rst_),
        .load (go_div || abort),
        .din  (go_div ? CNT_W'(DIV_CYCLES - 2) : '0),
        .en   (state == DIV),
        .cnt  (div_cnt),
        .zero (div_zero)
    );

    pipe_cnt u_fl_cnt (
        .clk  (clk),
        .rst  (rst_),
        .load (go_flush),
        .din  (CNT_W'(FLUSH_CYCLES - 1)),
        .en   (state == FLUSH),
        .cnt  (fl_cnt),
        .zero (fl_zero)
    );

    assign bus.div_busy = state == DIV;

    // state register
    always_ff @(posedge clk)
        state <= rst_ ? RUN : state_nxt;

    // next state: exception beats divide start/completion; FLUSH ignores every request
    always_comb begin
        state_nxt = state;
        go_div    = 1'b0;
        go_flush  = 1'b0;
        abort     = 1'b0;
        case (state)
            RUN: begin
                go_flush  = bus.excp_valid;
                go_div    = !bus.excp_valid && bus.div_start && !bus.stallreq_mem;
                state_nxt = go_flush ? FLUSH : go_div ? DIV : RUN;
            end
            DIV: begin
                go_flush  = bus.excp_valid;
                abort     = bus.excp_valid && !div_zero;
                state_nxt = go_flush ? FLUSH : div_zero ? RUN : DIV;
            end
            default: state_nxt = fl_zero ? RUN : FLUSH;
        endcase
    end

    // stall vector: nested patterns, so the highest requester alone decides
    always_comb begin
        ex_req    = bus.stallreq_ex || (state == RUN && bus.div_start) || (state == DIV && !div_zero);
        bus.stall = (rst_ || state == FLUSH) ? STALL_NONE :
                    bus.stallreq_mem         ? STALL_MEM  :
                    ex_req                   ? STALL_EX   :
                    bus.stallreq_id          ? STALL_ID   : STALL_NONE;
    end

    // registered flush, redirect target and divide pulses
    always_ff @(posedge clk)
        if (rst_) begin
            bus.flush     <= 1'b0;
            bus.new_pc    <= '0;
            bus.div_done  <= 1'b0;
            bus.div_abort <= 1'b0;
        end else begin
            bus.flush     <= go_flush || (state == FLUSH && |fl_cnt);
            bus.new_pc    <= go_flush ? bus.excp_vector : bus.new_pc;
            bus.div_done  <= (go_div && DIV_CYCLES == 2) ||
                             (state == DIV && !bus.excp_valid && div_cnt == CNT_W'(1));
            bus.div_abort <= abort;
        end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of stall priority, divide timing, abort and flush
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst_ = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;

    pipe_ctrl_if a();
    pipe_ctrl_if b();

    pipe_ctrl #(.DIV_CYCLES(32), .FLUSH_CYCLES(1)) dut_a (.clk(clk), .rst_(rst_), .bus(a));
    pipe_ctrl #(.DIV_CYCLES(2),  .FLUSH_CYCLES(3)) dut_b (.clk(clk), .rst_(rst_), .bus(b));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic probe;
        @(negedge clk);
    endtask

    task automatic idle_all;
        a.stallreq_id = 0; a.stallreq_ex = 0; a.stallreq_mem = 0;
        a.div_start = 0; a.excp_valid = 0; a.excp_vector = 32'h0;
        b.stallreq_id = 0; b.stallreq_ex = 0; b.stallreq_mem = 0;
        b.div_start = 0; b.excp_valid = 0; b.excp_vector = 32'h0;
    endtask

    task automatic test_reset;
        rst_ = 1'b1;
        a.stallreq_id = 1; a.stallreq_ex = 1; a.stallreq_mem = 1;
        a.div_start = 1; a.excp_valid = 1; a.excp_vector = 32'hdead_beef;
        b.stallreq_id = 1; b.stallreq_ex = 1; b.stallreq_mem = 1;
        b.div_start = 1; b.excp_valid = 1; b.excp_vector = 32'hdead_beef;
        repeat (3) tick;
        probe;
        n_run++; if (a.stall !== 6'b000000) begin n_fail++; $display("FAIL reset_stall: got %b want 000000", a.stall); end
        n_run++; if (a.flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", a.flush); end
        n_run++; if (a.new_pc !== 32'h0) begin n_fail++; $display("FAIL reset_new_pc: got %h want 0", a.new_pc); end
        n_run++; if (a.div_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", a.div_busy); end
        n_run++; if (b.stall !== 6'b000000) begin n_fail++; $display("FAIL reset_stall_b: got %b want 000000", b.stall); end
        tick;
        rst_ = 1'b0;
        idle_all;
        a.stallreq_id = 1;
        probe;
        n_run++; if (a.stall !== 6'b000111) begin n_fail++; $display("FAIL release_stall: got %b want 000111", a.stall); end
        tick;
        probe;
        n_run++; if (a.stall !== 6'b000111) begin n_fail++; $display("FAIL release_stall2: got %b want 000111", a.stall); end
        n_run++; if (a.flush !== 1'b0) begin n_fail++; $display("FAIL release_flush: got %b want 0", a.flush); end
        idle_all;
    endtask

    task automatic test_priority;
        logic [2:0] req [6] = '{3'b001, 3'b011, 3'b111, 3'b100, 3'b010, 3'b000};
        logic [5:0] exp [6] = '{6'b000111, 6'b001111, 6'b011111, 6'b011111, 6'b001111, 6'b000000};
        for (int i = 0; i < 6; i++) begin
            tick;
            {a.stallreq_mem, a.stallreq_ex, a.stallreq_id} = req[i];
            probe;
            n_run++; if (a.stall !== exp[i]) begin n_fail++; $display("FAIL priority req=%b: got %b want %b", req[i], a.stall, exp[i]); end
        end
        idle_all;
    endtask

    task automatic test_divide;
        logic [5:0] exp_stall;
        tick;
        a.div_start = 1;
        probe;
        n_run++; if (a.stall !== 6'b001111) begin n_fail++; $display("FAIL div_start_stall: got %b want 001111", a.stall); end
        n_run++; if (a.div_busy !== 1'b0) begin n_fail++; $display("FAIL div_start_busy: got %b want 0", a.div_busy); end
        for (int k = 1; k <= 32; k++) begin
            tick;
            a.div_start = 0;
            probe;
            exp_stall = (k <= 30) ? 6'b001111 : 6'b000000;
            n_run++; if (a.div_busy !== 1'(k <= 31)) begin n_fail++; $display("FAIL div_busy k=%0d: got %b want %b", k, a.div_busy, 1'(k <= 31)); end
            n_run++; if (a.div_done !== 1'(k == 31)) begin n_fail++; $display("FAIL div_done k=%0d: got %b want %b", k, a.div_done, 1'(k == 31)); end
            n_run++; if (a.stall !== exp_stall) begin n_fail++; $display("FAIL div_stall k=%0d: got %b want %b", k, a.stall, exp_stall); end
            n_run++; if (a.div_abort !== 1'b0) begin n_fail++; $display("FAIL div_abort k=%0d: got %b want 0", k, a.div_abort); end
        end
    endtask

    task automatic test_abort;
        logic seen_done = 1'b0;
        tick;
        a.div_start = 1;
        tick;
        a.div_start = 0;
        repeat (4) tick;
        a.excp_valid = 1;
        a.excp_vector = 32'h0000_0180;
        probe;
        n_run++; if (a.div_busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b want 1", a.div_busy); end
        n_run++; if (a.stall !== 6'b001111) begin n_fail++; $display("FAIL abort_pre_stall: got %b want 001111", a.stall); end
        n_run++; if (a.div_abort !== 1'b0) begin n_fail++; $display("FAIL abort_pre_pulse: got %b want 0", a.div_abort); end
        tick;
        idle_all;
        probe;
        n_run++; if (a.div_abort !== 1'b1) begin n_fail++; $display("FAIL abort_pulse: got %b want 1", a.div_abort); end
        n_run++; if (a.flush !== 1'b1) begin n_fail++; $display("FAIL abort_flush: got %b want 1", a.flush); end
        n_run++; if (a.new_pc !== 32'h0000_0180) begin n_fail++; $display("FAIL abort_new_pc: got %h want 00000180", a.new_pc); end
        n_run++; if (a.div_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", a.div_busy); end
        n_run++; if (a.stall !== 6'b000000) begin n_fail++; $display("FAIL abort_stall: got %b want 000000", a.stall); end
        n_run++; if (a.div_done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", a.div_done); end
        tick;
        probe;
        n_run++; if (a.div_abort !== 1'b0) begin n_fail++; $display("FAIL abort_pulse_end: got %b want 0", a.div_abort); end
        n_run++; if (a.flush !== 1'b0) begin n_fail++; $display("FAIL abort_flush_end: got %b want 0", a.flush); end
        n_run++; if (a.new_pc !== 32'h0000_0180) begin n_fail++; $display("FAIL abort_new_pc_hold: got %h want 00000180", a.new_pc); end
        repeat (32) begin
            tick;
            probe;
            seen_done = seen_done | a.div_done | a.div_busy;
        end
        n_run++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b want 0", seen_done); end
    endtask

    task automatic test_conflicts;
        tick;
        a.div_start = 1; a.excp_valid = 1; a.excp_vector = 32'h0000_0200;
        probe;
        n_run++; if (a.stall !== 6'b001111) begin n_fail++; $display("FAIL both_stall: got %b want 001111", a.stall); end
        tick;
        idle_all;
        probe;
        n_run++; if (a.flush !== 1'b1) begin n_fail++; $display("FAIL both_flush: got %b want 1", a.flush); end
        n_run++; if (a.new_pc !== 32'h0000_0200) begin n_fail++; $display("FAIL both_new_pc: got %h want 00000200", a.new_pc); end
        n_run++; if (a.div_busy !== 1'b0) begin n_fail++; $display("FAIL both_busy: got %b want 0", a.div_busy); end
        tick;
        probe;
        n_run++; if (a.div_busy !== 1'b0) begin n_fail++; $display("FAIL both_busy2: got %b want 0", a.div_busy); end
        n_run++; if (a.flush !== 1'b0) begin n_fail++; $display("FAIL both_flush2: got %b want 0", a.flush); end
        tick;
        a.div_start = 1; a.stallreq_mem = 1;
        probe;
        n_run++; if (a.stall !== 6'b011111) begin n_fail++; $display("FAIL memdiv_stall: got %b want 011111", a.stall); end
        tick;
        idle_all;
        probe;
        n_run++; if (a.div_busy !== 1'b0) begin n_fail++; $display("FAIL memdiv_busy: got %b want 0", a.div_busy); end
        n_run++; if (a.stall !== 6'b000000) begin n_fail++; $display("FAIL memdiv_stall2: got %b want 000000", a.stall); end
        tick;
        a.stallreq_mem = 1; a.excp_valid = 1; a.excp_vector = 32'h0000_0240;
        probe;
        n_run++; if (a.stall !== 6'b011111) begin n_fail++; $display("FAIL memexc_stall: got %b want 011111", a.stall); end
        tick;
        a.excp_valid = 0;
        probe;
        n_run++; if (a.flush !== 1'b1) begin n_fail++; $display("FAIL memexc_flush: got %b want 1", a.flush); end
        n_run++; if (a.stall !== 6'b000000) begin n_fail++; $display("FAIL memexc_flush_stall: got %b want 000000", a.stall); end
        n_run++; if (a.new_pc !== 32'h0000_0240) begin n_fail++; $display("FAIL memexc_new_pc: got %h want 00000240", a.new_pc); end
        tick;
        probe;
        n_run++; if (a.flush !== 1'b0) begin n_fail++; $display("FAIL memexc_flush_end: got %b want 0", a.flush); end
        n_run++; if (a.stall !== 6'b011111) begin n_fail++; $display("FAIL memexc_stall_back: got %b want 011111", a.stall); end
        idle_all;
    endtask

    task automatic test_flush3;
        int flush_cycles = 0;
        tick;
        b.excp_valid = 1; b.excp_vector = 32'h0000_0300;
        probe;
        n_run++; if (b.flush !== 1'b0) begin n_fail++; $display("FAIL f3_pre_flush: got %b want 0", b.flush); end
        tick;
        b.excp_vector = 32'h0000_0400; b.div_start = 1; b.stallreq_mem = 1;
        probe;
        flush_cycles += int'(b.flush);
        n_run++; if (b.new_pc !== 32'h0000_0300) begin n_fail++; $display("FAIL f3_new_pc1: got %h want 00000300", b.new_pc); end
        n_run++; if (b.stall !== 6'b000000) begin n_fail++; $display("FAIL f3_stall1: got %b want 000000", b.stall); end
        tick;
        probe;
        flush_cycles += int'(b.flush);
        n_run++; if (b.new_pc !== 32'h0000_0300) begin n_fail++; $display("FAIL f3_new_pc2: got %h want 00000300", b.new_pc); end
        tick;
        probe;
        flush_cycles += int'(b.flush);
        n_run++; if (b.flush !== 1'b1) begin n_fail++; $display("FAIL f3_flush3: got %b want 1", b.flush); end
        tick;
        idle_all;
        probe;
        flush_cycles += int'(b.flush);
        n_run++; if (b.flush !== 1'b0) begin n_fail++; $display("FAIL f3_flush_end: got %b want 0", b.flush); end
        n_run++; if (b.new_pc !== 32'h0000_0300) begin n_fail++; $display("FAIL f3_new_pc_end: got %h want 00000300", b.new_pc); end
        n_run++; if (b.div_busy !== 1'b0) begin n_fail++; $display("FAIL f3_busy: got %b want 0", b.div_busy); end
        tick;
        probe;
        flush_cycles += int'(b.flush);
        n_run++; if (b.div_busy !== 1'b0) begin n_fail++; $display("FAIL f3_busy2: got %b want 0", b.div_busy); end
        n_run++; if (flush_cycles != 3) begin n_fail++; $display("FAIL f3_flush_len: got %0d want 3", flush_cycles); end
    endtask

    task automatic test_div_short;
        tick;
        b.div_start = 1;
        probe;
        n_run++; if (b.stall !== 6'b001111) begin n_fail++; $display("FAIL d2_start_stall: got %b want 001111", b.stall); end
        tick;
        b.div_start = 0;
        probe;
        n_run++; if (b.div_busy !== 1'b1) begin n_fail++; $display("FAIL d2_busy: got %b want 1", b.div_busy); end
        n_run++; if (b.div_done !== 1'b1) begin n_fail++; $display("FAIL d2_done: got %b want 1", b.div_done); end
        n_run++; if (b.stall !== 6'b000000) begin n_fail++; $display("FAIL d2_stall: got %b want 000000", b.stall); end
        tick;
        probe;
        n_run++; if (b.div_busy !== 1'b0) begin n_fail++; $display("FAIL d2_busy_end: got %b want 0", b.div_busy); end
        n_run++; if (b.div_done !== 1'b0) begin n_fail++; $display("FAIL d2_done_end: got %b want 0", b.div_done); end
    endtask

    task automatic test_reset_mid;
        logic seen_done = 1'b0;
        tick;
        a.div_start = 1;
        tick;
        a.div_start = 0;
        repeat (3) tick;
        probe;
        n_run++; if (a.div_busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_pre: got %b want 1", a.div_busy); end
        tick;
        rst_ = 1'b1;
        probe;
        n_run++; if (a.stall !== 6'b000000) begin n_fail++; $display("FAIL rmid_stall_rst: got %b want 000000", a.stall); end
        tick;
        rst_ = 1'b0;
        probe;
        n_run++; if (a.div_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", a.div_busy); end
        n_run++; if (a.stall !== 6'b000000) begin n_fail++; $display("FAIL rmid_stall: got %b want 000000", a.stall); end
        n_run++; if (a.new_pc !== 32'h0) begin n_fail++; $display("FAIL rmid_new_pc: got %h want 0", a.new_pc); end
        repeat (32) begin
            tick;
            probe;
            seen_done = seen_done | a.div_done;
        end
        n_run++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rmid_no_done: got %b want 0", seen_done); end
    endtask

    initial begin
        idle_all;
        test_reset;
        test_priority;
        test_divide;
        test_abort;
        test_conflicts;
        test_flush3;
        test_div_short;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
